// File: rtl/ddr4_init_sequencer.sv
// rtl/ddr4_init_sequencer.sv - DDR4 power-up init sequencer (reset, CKE, MRS, ZQCL); ZQCL stage enabled by INIT_ZQCL_EN
module ddr4_init_sequencer #(
    parameter int CNT_W    = 16,
    parameter int T_RESET  = 200,
    parameter int T_CKE_L  = 100,
    parameter int T_XPR    = 40,
    parameter int T_MRD    = 8,
    parameter int T_MOD    = 24,
    parameter int T_ZQINIT = 1024
) (
    input  logic        clock_t,
    input  logic        reset_n,
    input  logic        init_start,
    input  logic [97:0] mr_cfg,
    output logic        init_busy,
    output logic        init_done,
    output logic        dram_reset_n,
    output logic        cke,
    output logic        cs_n,
    output logic        act_n,
    output logic        ras_n_a16,
    output logic        cas_n_a15,
    output logic        we_n_a14,
    output logic [1:0]  bg,
    output logic [1:0]  ba,
    output logic [13:0] addr
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LOW,
        S_CKE_WAIT,
        S_XPR_WAIT,
        S_MRS_ISSUE,
        S_MRD_WAIT,
        S_MOD_WAIT,
`ifdef INIT_ZQCL_EN
        S_ZQCL,
        S_ZQ_WAIT,
`endif
        S_DONE
    } state_t;

    // Counter load values: a state lasting T cycles starts at T-1 and exits on 0.
    // The MRS cycle itself counts as the first cycle of the following MRD/MOD gap.
    localparam logic [CNT_W-1:0] LD_RESET  = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] LD_CKE_L  = CNT_W'(T_CKE_L - 1);
    localparam logic [CNT_W-1:0] LD_XPR    = CNT_W'(T_XPR - 1);
    localparam logic [CNT_W-1:0] LD_MRD    = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] LD_MOD    = CNT_W'(T_MOD - 1);
`ifdef INIT_ZQCL_EN
    localparam logic [CNT_W-1:0] LD_ZQINIT = CNT_W'(T_ZQINIT - 1);
`endif
    localparam logic [2:0]       LAST_MR   = 3'd6;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [2:0]         mr_idx;
    logic [2:0]         mr_idx_n;
    logic               capture;
    logic [97:0]        mr_q;

    logic [2:0]         mr_num;
    logic [13:0]        mr_data;
    logic               dram_reset_d;
    logic               cke_d;
    logic               cs_d;
    logic               act_d;
    logic               ras_d;
    logic               cas_d;
    logic               we_d;
    logic [1:0]         bg_d;
    logic [1:0]         ba_d;
    logic [13:0]        addr_d;
    logic               busy_d;
    logic               done_d;

    // State, delay counter, MR index and captured MR configuration
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mr_idx <= 3'd0;
            mr_q   <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mr_idx <= mr_idx_n;
            if (capture) begin
                mr_q <= mr_cfg;
            end
        end
    end

    // Next-state, counter reload and MR index sequencing
    always_comb begin
        state_n  = state;
        cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
        mr_idx_n = mr_idx;
        capture  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (init_start) begin
                    state_n  = S_RST_LOW;
                    cnt_n    = LD_RESET;
                    mr_idx_n = 3'd0;
                    capture  = 1'b1;
                end
            end
            S_RST_LOW: begin
                if (cnt == '0) begin
                    state_n = S_CKE_WAIT;
                    cnt_n   = LD_CKE_L;
                end
            end
            S_CKE_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_XPR_WAIT;
                    cnt_n   = LD_XPR;
                end
            end
            S_XPR_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_MRS_ISSUE;
                    cnt_n   = LD_MRD;
                end
            end
            S_MRS_ISSUE: begin
                state_n = (mr_idx == LAST_MR) ? S_MOD_WAIT : S_MRD_WAIT;
            end
            S_MRD_WAIT: begin
                if (cnt == '0) begin
                    state_n  = S_MRS_ISSUE;
                    mr_idx_n = mr_idx + 3'd1;
                    cnt_n    = (mr_idx == LAST_MR - 3'd1) ? LD_MOD : LD_MRD;
                end
            end
            S_MOD_WAIT: begin
                if (cnt == '0) begin
`ifdef INIT_ZQCL_EN
                    state_n = S_ZQCL;
                    cnt_n   = LD_ZQINIT;
`else
                    state_n = S_DONE;
`endif
                end
            end
`ifdef INIT_ZQCL_EN
            S_ZQCL: begin
                state_n = (cnt == '0) ? S_DONE : S_ZQ_WAIT;
            end
            S_ZQ_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_DONE;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // MR issue order is MR3, MR6, MR5, MR4, MR2, MR1, MR0
    always_comb begin
        mr_num  = 3'd0;
        mr_data = mr_q[13:0];
        case (mr_idx_n)
            3'd0:    begin mr_num = 3'd3; mr_data = mr_q[55:42]; end
            3'd1:    begin mr_num = 3'd6; mr_data = mr_q[97:84]; end
            3'd2:    begin mr_num = 3'd5; mr_data = mr_q[83:70]; end
            3'd3:    begin mr_num = 3'd4; mr_data = mr_q[69:56]; end
            3'd4:    begin mr_num = 3'd2; mr_data = mr_q[41:28]; end
            3'd5:    begin mr_num = 3'd1; mr_data = mr_q[27:14]; end
            default: begin mr_num = 3'd0; mr_data = mr_q[13:0];  end
        endcase
    end

    // Pin values for the upcoming cycle, decoded from the next state; DES unless a command
    always_comb begin
        dram_reset_d = !(state_n inside {S_IDLE, S_RST_LOW});
        cke_d        = !(state_n inside {S_IDLE, S_RST_LOW, S_CKE_WAIT});
        busy_d       = !(state_n inside {S_IDLE, S_DONE});
        done_d       = (state_n == S_DONE);
        cs_d         = 1'b1;
        act_d        = 1'b1;
        ras_d        = 1'b1;
        cas_d        = 1'b1;
        we_d         = 1'b1;
        bg_d         = 2'b00;
        ba_d         = 2'b00;
        addr_d       = 14'd0;
        if (state_n == S_MRS_ISSUE) begin
            cs_d   = 1'b0;
            ras_d  = 1'b0;
            cas_d  = 1'b0;
            we_d   = 1'b0;
            bg_d   = {1'b0, mr_num[2]};
            ba_d   = mr_num[1:0];
            addr_d = mr_data;
        end
`ifdef INIT_ZQCL_EN
        if (state_n == S_ZQCL) begin
            cs_d   = 1'b0;
            we_d   = 1'b0;
            addr_d = 14'h0400;
        end
`endif
    end

    // Registered pins so the command bus is glitch-free
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            dram_reset_n <= 1'b0;
            cke          <= 1'b0;
            cs_n         <= 1'b1;
            act_n        <= 1'b1;
            ras_n_a16    <= 1'b1;
            cas_n_a15    <= 1'b1;
            we_n_a14     <= 1'b1;
            bg           <= 2'b00;
            ba           <= 2'b00;
            addr         <= 14'd0;
            init_busy    <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            dram_reset_n <= dram_reset_d;
            cke          <= cke_d;
            cs_n         <= cs_d;
            act_n        <= act_d;
            ras_n_a16    <= ras_d;
            cas_n_a15    <= cas_d;
            we_n_a14     <= we_d;
            bg           <= bg_d;
            ba           <= ba_d;
            addr         <= addr_d;
            init_busy    <= busy_d;
            init_done    <= done_d;
        end
    end

endmodule

// File: tb/tb_ddr4_init_sequencer.sv
// tb/tb_ddr4_init_sequencer.sv - scoreboard bench for ddr4_init_sequencer (nominal and minimum timing instances)
module tb_ddr4_init_sequencer;

    localparam logic [26:0] RESET_VEC = {2'b00, 5'b11111, 18'd0, 2'b00};

    typedef struct {
        int          kind;
        int          cyc;
        logic [17:0] cmd;
    } ev_t;

    logic        clock_t = 1'b0;
    logic        reset_n;
    logic        init_start;
    logic        sel;
    logic [97:0] mr_cfg;
    logic [97:0] exp_mr;
    logic        start_a;
    logic        start_b;

    logic a_busy, a_done, a_rst, a_cke, a_cs, a_act, a_ras, a_cas, a_we;
    logic b_busy, b_done, b_rst, b_cke, b_cs, b_act, b_ras, b_cas, b_we;
    logic [1:0]  a_bg, a_ba, b_bg, b_ba;
    logic [13:0] a_addr, b_addr;
    logic [26:0] a_vec, b_vec, m_vec;
    logic        m_rst, m_cke, m_cs, m_act, m_ras, m_cas, m_we, m_busy, m_done;
    logic [17:0] m_cmd;

    ev_t  q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   rel = 0;
    logic arm = 1'b0;
    int   des_bad = 0;
    logic p_rst = 1'b0;
    logic p_cke = 1'b0;
    logic p_done = 1'b0;
    int   dc;
    logic [127:0] rnd;

    always #5 clock_t = ~clock_t;

    assign start_a = init_start & ~sel;
    assign start_b = init_start & sel;

    ddr4_init_sequencer u_nom (
        .clock_t(clock_t), .reset_n(reset_n), .init_start(start_a), .mr_cfg(mr_cfg),
        .init_busy(a_busy), .init_done(a_done), .dram_reset_n(a_rst), .cke(a_cke),
        .cs_n(a_cs), .act_n(a_act), .ras_n_a16(a_ras), .cas_n_a15(a_cas), .we_n_a14(a_we),
        .bg(a_bg), .ba(a_ba), .addr(a_addr)
    );

    ddr4_init_sequencer #(
        .T_RESET(1), .T_CKE_L(1), .T_XPR(1), .T_MRD(2), .T_MOD(2), .T_ZQINIT(1)
    ) u_min (
        .clock_t(clock_t), .reset_n(reset_n), .init_start(start_b), .mr_cfg(mr_cfg),
        .init_busy(b_busy), .init_done(b_done), .dram_reset_n(b_rst), .cke(b_cke),
        .cs_n(b_cs), .act_n(b_act), .ras_n_a16(b_ras), .cas_n_a15(b_cas), .we_n_a14(b_we),
        .bg(b_bg), .ba(b_ba), .addr(b_addr)
    );

    assign a_vec  = {a_rst, a_cke, a_cs, a_act, a_ras, a_cas, a_we, a_bg, a_ba, a_addr, a_busy, a_done};
    assign b_vec  = {b_rst, b_cke, b_cs, b_act, b_ras, b_cas, b_we, b_bg, b_ba, b_addr, b_busy, b_done};
    assign m_vec  = sel ? b_vec : a_vec;
    assign m_rst  = m_vec[26];
    assign m_cke  = m_vec[25];
    assign m_cs   = m_vec[24];
    assign m_act  = m_vec[23];
    assign m_ras  = m_vec[22];
    assign m_cas  = m_vec[21];
    assign m_we   = m_vec[20];
    assign m_cmd  = m_vec[19:2];
    assign m_busy = m_vec[1];
    assign m_done = m_vec[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (rel cycle %0d)", tag, got, exp, rel);
        end
    endtask

    function automatic logic [2:0] mr_of(input int i);
        case (i)
            0: return 3'd3;
            1: return 3'd6;
            2: return 3'd5;
            3: return 3'd4;
            4: return 3'd2;
            5: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    task automatic push(input int kind, input int cyc, input logic [17:0] cmd);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.cmd  = cmd;
        q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input logic [17:0] cmd);
        ev_t e;
        if (q.size() == 0) begin
            chk("sb_extra_event", kind, 32'hFFFF_FFFF);
        end else begin
            e = q.pop_front();
            chk($sformatf("ev%0d_kind", e.kind), kind, e.kind);
            chk($sformatf("ev%0d_cycle", e.kind), rel, e.cyc);
            if (kind == 2 || kind == 3) begin
                chk($sformatf("ev%0d_cmd", e.kind), {14'd0, cmd}, {14'd0, e.cmd});
            end
            if (kind == 4) begin
                chk("done_busy_low", {31'd0, m_busy}, 32'd0);
            end
        end
    endtask

    // Cycle counter relative to an accepted start (cycle 1 = first cycle after the start edge)
    always @(posedge clock_t) begin
        rel <= arm ? 1 : rel + 1;
        arm <= 1'b0;
    end

    // Output monitor: detects pin events and pops the scoreboard; tracks DES cleanliness
    always @(negedge clock_t) begin : mon
        int kind;
        if (m_rst && !p_rst) sb_pop(0, 18'd0);
        if (m_cke && !p_cke) sb_pop(1, 18'd0);
        if (!m_cs) begin
            if (!m_ras && !m_cas && !m_we && m_act) kind = 2;
            else if (m_ras && m_cas && !m_we && m_act) kind = 3;
            else kind = 9;
            sb_pop(kind, m_cmd);
        end else if ({m_act, m_ras, m_cas, m_we, m_cmd} != {4'b1111, 18'd0}) begin
            des_bad++;
        end
        if (m_done && !p_done) sb_pop(4, 18'd0);
        p_rst  <= m_rst;
        p_cke  <= m_cke;
        p_done <= m_done;
    end

    task automatic do_start(input logic which, output int done_cyc);
        int tr, tc, tx, tm, tmod, tz, c;
        logic [2:0] mn;
        tr = which ? 1 : 200;
        tc = which ? 1 : 100;
        tx = which ? 1 : 40;
        tm = which ? 2 : 8;
        tmod = which ? 2 : 24;
        tz = which ? 1 : 1024;
        @(negedge clock_t);
        sel = which;
        exp_mr = mr_cfg;
        c = tr + 1;
        push(0, c, 18'd0);
        c += tc;
        push(1, c, 18'd0);
        c += tx;
        for (int i = 0; i < 7; i++) begin
            mn = mr_of(i);
            push(2, c, {1'b0, mn[2], mn[1:0], exp_mr[14*mn +: 14]});
            if (i < 6) c += tm;
        end
        c += tmod;
`ifdef INIT_ZQCL_EN
        push(3, c, {4'b0000, 14'h0400});
        c += tz;
`endif
        push(4, c, 18'd0);
        done_cyc = c;
        init_start = 1'b1;
        arm = 1'b1;
        @(negedge clock_t);
        init_start = 1'b0;
        chk("start_entry_pins", {28'd0, m_rst, m_cke, m_busy, m_done}, 32'b0010);
    endtask

    task automatic wait_rel(input int r);
        int n = 0;
        while (rel < r && n < 5000) begin
            @(negedge clock_t);
            n++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge clock_t);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        init_start = 1'b0;
        sel = 1'b0;
        mr_cfg = '0;
        exp_mr = '0;
        repeat (3) @(negedge clock_t);
        chk("reset_nom", {5'd0, a_vec}, {5'd0, RESET_VEC});
        chk("reset_min", {5'd0, b_vec}, {5'd0, RESET_VEC});
        reset_n = 1'b1;
        repeat (2) @(negedge clock_t);
        chk("idle_nom", {5'd0, a_vec}, {5'd0, RESET_VEC});

        // Nominal run with known MR0/MR3, mid-run cfg change and ignored start in XPR_WAIT
        rnd = {$urandom, $urandom, $urandom, $urandom};
        mr_cfg = rnd[97:0];
        mr_cfg[13:0] = 14'h0A55;
        mr_cfg[55:42] = 14'h0004;
        do_start(1'b0, dc);
        repeat (5) @(negedge clock_t);
        mr_cfg = ~mr_cfg;
        wait_rel(320);
        init_start = 1'b1;
        @(negedge clock_t);
        init_start = 1'b0;
        wait_drain(3000);
        @(negedge clock_t);
        chk("done_hold", {28'd0, m_done, m_busy, m_cke, m_rst}, 32'b1011);

        // Re-init from DONE, then asynchronous reset during MRD_WAIT
        rnd = {$urandom, $urandom, $urandom, $urandom};
        mr_cfg = rnd[97:0];
        do_start(1'b0, dc);
        wait_rel(345);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {5'd0, a_vec}, {5'd0, RESET_VEC});
        q.delete();
        @(negedge clock_t);
        reset_n = 1'b1;
        @(negedge clock_t);
        chk("post_reset_idle", {5'd0, a_vec}, {5'd0, RESET_VEC});

        // Full run after the abort
        do_start(1'b0, dc);
        wait_drain(3000);

        // Minimum-timing instance; start coinciding with completion is ignored
        rnd = {$urandom, $urandom, $urandom, $urandom};
        mr_cfg = rnd[97:0];
        do_start(1'b1, dc);
        wait_rel(dc - 1);
        init_start = 1'b1;
        @(negedge clock_t);
        init_start = 1'b0;
        @(negedge clock_t);
        chk("start_at_done_ignored", {30'd0, m_done, m_busy}, 32'b10);
        wait_drain(100);

        chk("des_clean", des_bad, 0);
        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
